mandelbrot_coord_dispatcher: RTL and testbench

//  Initiator side of the processor work-queue handshake. Raster-scans the full screen and hands one

---
 rtl/mandelbrot_coord_dispatcher.sv | 118 +++++++++++
 tb/tb_mandelbrot_coord_dispatcher.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_coord_dispatcher.sv
// Raster-scan coordinate dispatcher: issues one {x,y} pixel per cycle, round-robin,
// to whichever Mandelbrot processor is ready and not already holding a fresh job.
module mandelbrot_coord_dispatcher #(
    parameter int NUM_PROC = 4,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iStart,
    input  logic [NUM_PROC-1:0] iProcReady,
    output logic [NUM_PROC-1:0] oDataVal,
    output logic [18:0]         oCoord,
    output logic                oBusy,
    output logic                oDone,
    output logic [18:0]         oIssueCount
);

    localparam int          PW     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [9:0]  X_LAST = 10'(H_RES - 1);
    localparam logic [8:0]  Y_LAST = 9'(V_RES - 1);
    localparam logic [18:0] TOTAL  = 19'(H_RES * V_RES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state;
    logic [9:0]          x;
    logic [8:0]          y;
    logic [PW-1:0]       rr_ptr;
    logic [NUM_PROC-1:0] hold_mask;

    logic [NUM_PROC-1:0] elig_p0;
    logic                grant_vld_p0;
    logic [PW-1:0]       grant_idx_p0;
    logic [NUM_PROC-1:0] grant_vec_p0;
    logic [PW-1:0]       cand;
    logic [PW-1:0]       rr_next_p0;

    // Stage p0: eligibility and rotating-priority grant from the current samples
    always_comb begin
        elig_p0      = iProcReady & ~hold_mask;
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        grant_vec_p0 = '0;
        cand         = '0;
        if (state == SCAN && oIssueCount != TOTAL) begin
            // Walk from the farthest offset down so the nearest eligible one wins.
            for (int i = NUM_PROC - 1; i >= 0; i--) begin
                cand = PW'((int'(rr_ptr) + i) % NUM_PROC);
                if (elig_p0[cand]) begin
                    grant_vld_p0 = 1'b1;
                    grant_idx_p0 = cand;
                end
            end
            if (grant_vld_p0) begin
                grant_vec_p0[grant_idx_p0] = 1'b1;
            end
        end
        rr_next_p0 = PW'((int'(grant_idx_p0) + 1) % NUM_PROC);
    end

    // Stage p1: registered issue, scan position and frame control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            rr_ptr      <= '0;
            hold_mask   <= '0;
            oDataVal    <= '0;
            oCoord      <= '0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oIssueCount <= '0;
        end else begin
            // A processor stays masked until it has visibly dropped ready once.
            hold_mask <= (hold_mask & iProcReady) | grant_vec_p0;
            oDataVal  <= grant_vec_p0;
            oDone     <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state       <= SCAN;
                        oBusy       <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        oIssueCount <= '0;
                    end
                end
                SCAN: begin
                    if (oIssueCount == TOTAL) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end else if (grant_vld_p0) begin
                        oCoord      <= {x, y};
                        oIssueCount <= oIssueCount + 19'd1;
                        rr_ptr      <= rr_next_p0;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= (y == Y_LAST) ? 9'd0 : y + 9'd1;
                        end else begin
                            x <= x + 10'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_coord_dispatcher.sv
// Directed bench for mandelbrot_coord_dispatcher: vector table for the handshake basics,
// hand-written sequences for stall, async reset, line wrap and end of frame.
module tb_mandelbrot_coord_dispatcher;

    localparam int NP = 4;
    localparam int HR = 640;
    localparam int VR = 4;
    localparam int FRAME = HR * VR;

    logic          clk = 1'b0;
    logic          reset;
    logic          iStart;
    logic [NP-1:0] iProcReady;
    logic [NP-1:0] oDataVal;
    logic [18:0]   oCoord;
    logic          oBusy;
    logic          oDone;
    logic [18:0]   oIssueCount;

    int checks = 0;
    int errors = 0;

    mandelbrot_coord_dispatcher #(.NUM_PROC(NP), .H_RES(HR), .V_RES(VR)) dut (
        .clk        (clk),
        .reset      (reset),
        .iStart     (iStart),
        .iProcReady (iProcReady),
        .oDataVal   (oDataVal),
        .oCoord     (oCoord),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oIssueCount(oIssueCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [3:0]  ready;
        logic [3:0]  dv;
        logic [18:0] coord;
        logic        busy;
        logic        done;
        logic [18:0] cnt;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [18:0] cc(input int xx, input int yy);
        return {10'(xx), 9'(yy)};
    endfunction

    function automatic vec_t mk(input logic st, input logic [3:0] rd, input logic [3:0] dv,
                                input logic [18:0] co, input logic bz, input logic dn,
                                input int cn);
        vec_t v;
        v.start = st; v.ready = rd; v.dv = dv; v.coord = co;
        v.busy = bz; v.done = dn; v.cnt = 19'(cn);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int  ex, ey, n_iss, bcnt;
    bit  prev_last, done_seen, phase;

    initial begin
        // Handshake basics: round robin, ready-hold masking, iStart ignored while scanning
        vecs[0]  = mk(0, 4'hF, 4'h0, cc(0,0), 0, 0, 0);
        vecs[1]  = mk(1, 4'h0, 4'h0, cc(0,0), 1, 0, 0);
        vecs[2]  = mk(0, 4'hF, 4'h1, cc(0,0), 1, 0, 1);
        vecs[3]  = mk(0, 4'hF, 4'h2, cc(1,0), 1, 0, 2);
        vecs[4]  = mk(0, 4'hF, 4'h4, cc(2,0), 1, 0, 3);
        vecs[5]  = mk(0, 4'hF, 4'h8, cc(3,0), 1, 0, 4);
        vecs[6]  = mk(0, 4'hF, 4'h0, cc(3,0), 1, 0, 4);
        vecs[7]  = mk(0, 4'h0, 4'h0, cc(3,0), 1, 0, 4);
        vecs[8]  = mk(0, 4'h1, 4'h1, cc(4,0), 1, 0, 5);
        vecs[9]  = mk(0, 4'h1, 4'h0, cc(4,0), 1, 0, 5);
        vecs[10] = mk(0, 4'h1, 4'h0, cc(4,0), 1, 0, 5);
        vecs[11] = mk(0, 4'h0, 4'h0, cc(4,0), 1, 0, 5);
        vecs[12] = mk(0, 4'h1, 4'h1, cc(5,0), 1, 0, 6);
        vecs[13] = mk(0, 4'h9, 4'h8, cc(6,0), 1, 0, 7);
        vecs[14] = mk(0, 4'h0, 4'h0, cc(6,0), 1, 0, 7);
        vecs[15] = mk(1, 4'hF, 4'h1, cc(7,0), 1, 0, 8);

        reset = 1'b0;
        iStart = 1'b0;
        iProcReady = '0;
        repeat (2) tick();
        chk("rst_dv", oDataVal, 0);
        chk("rst_coord", oCoord, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_cnt", oIssueCount, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            iStart = vecs[i].start;
            iProcReady = vecs[i].ready;
            tick();
            chk($sformatf("v%0d_dv", i), oDataVal, vecs[i].dv);
            chk($sformatf("v%0d_coord", i), oCoord, vecs[i].coord);
            chk($sformatf("v%0d_busy", i), oBusy, vecs[i].busy);
            chk($sformatf("v%0d_done", i), oDone, vecs[i].done);
            chk($sformatf("v%0d_cnt", i), oIssueCount, vecs[i].cnt);
        end
        iStart = 1'b0;

        // Long stall with nobody ready, then resume at the next coordinate
        iProcReady = 4'h0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("stall_dv", oDataVal, 0);
            chk("stall_coord", oCoord, cc(7,0));
        end
        iProcReady = 4'hF;
        tick();
        chk("resume_dv", oDataVal, 4'h2);
        chk("resume_coord", oCoord, cc(8,0));
        chk("resume_cnt", oIssueCount, 9);

        // Async reset between edges, iStart held during reset
        #2;
        reset = 1'b0;
        iStart = 1'b1;
        #2;
        chk("arst_dv", oDataVal, 0);
        chk("arst_coord", oCoord, 0);
        chk("arst_busy", oBusy, 0);
        chk("arst_cnt", oIssueCount, 0);
        tick();
        iStart = 1'b0;
        reset = 1'b1;
        iProcReady = 4'hF;
        tick();
        chk("post_rst_busy", oBusy, 0);
        chk("post_rst_dv", oDataVal, 0);
        iStart = 1'b1;
        iProcReady = 4'h0;
        tick();
        iStart = 1'b0;
        chk("restart_busy", oBusy, 1);
        chk("restart_cnt", oIssueCount, 0);
        iProcReady = 4'hF;
        tick();
        chk("restart_dv", oDataVal, 4'h1);
        chk("restart_coord", oCoord, cc(0,0));
        chk("restart_cnt1", oIssueCount, 1);

        // Single busy processor (ready high 2 cycles after accept, then 3 low) across a line wrap
        ex = 1; ey = 0; n_iss = 1; bcnt = 5;
        iProcReady = 4'h1;
        for (int c = 0; c < 20000 && n_iss < HR + 2; c++) begin
            tick();
            if (oDataVal != 0) begin
                chk("p0_dv", oDataVal, 4'h1);
                chk("p0_coord", oCoord, cc(ex, ey));
                ex++;
                if (ex == HR) begin ex = 0; ey++; end
                n_iss++;
                bcnt = 5;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            iProcReady = {3'b000, (bcnt == 0) || (bcnt >= 4)};
        end
        chk("wrap_issues", n_iss, HR + 2);
        chk("wrap_cnt", oIssueCount, HR + 2);
        chk("wrap_coord", oCoord, cc(1,1));

        // All processors toggling ready until the end of frame
        prev_last = 0; done_seen = 0; phase = 1;
        for (int c = 0; c < 20000 && !done_seen; c++) begin
            iProcReady = phase ? 4'hF : 4'h0;
            phase = ~phase;
            tick();
            if (oDone) begin
                done_seen = 1;
                chk("done_after_last", prev_last, 1);
                chk("done_cnt", oIssueCount, FRAME);
                chk("done_busy", oBusy, 1);
                chk("done_dv", oDataVal, 0);
            end else begin
                prev_last = 0;
                if (oDataVal != 0) begin
                    chk("frame_onehot", $onehot(oDataVal), 1);
                    chk("frame_coord", oCoord, cc(ex, ey));
                    prev_last = (ex == HR - 1) && (ey == VR - 1);
                    ex++;
                    if (ex == HR) begin ex = 0; ey = (ey == VR - 1) ? 0 : ey + 1; end
                end
            end
        end
        chk("done_seen", done_seen, 1);
        iProcReady = 4'hF;
        tick();
        chk("idle_busy", oBusy, 0);
        chk("idle_done", oDone, 0);
        chk("idle_dv", oDataVal, 0);
        chk("idle_coord", oCoord, cc(HR - 1, VR - 1));
        repeat (3) tick();
        chk("cnt_hold", oIssueCount, FRAME);
        iStart = 1'b1;
        iProcReady = 4'h0;
        tick();
        iStart = 1'b0;
        chk("new_frame_cnt", oIssueCount, 0);
        chk("new_frame_busy", oBusy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
